// File: rtl/spmv_row_accumulator.sv
// Integer SpMV row accumulator: multiplies the lanes of each beat, reduces the beat and
// accumulates beats of the same row. Emits one {row, dot-product} result per row.
module spmv_row_accumulator #(
    parameter int VECTOR_LENGTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int PARALLELISM   = 4,
    localparam int ADDR_WIDTH   = $clog2(VECTOR_LENGTH)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [PARALLELISM*DATA_WIDTH-1:0] in_val,
    input  logic [PARALLELISM*DATA_WIDTH-1:0] in_x,
    input  logic [PARALLELISM-1:0]            in_mask,
    input  logic [ADDR_WIDTH-1:0]             in_r_idx,
    input  logic                              in_row_last,
    input  logic                              in_mat_last,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic [ADDR_WIDTH-1:0]             out_r_idx,
    output logic                              out_last,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              done,
    output logic                              protocol_err
);

    logic                              adv;
    logic                              row_last_eff;
    logic [PARALLELISM*DATA_WIDTH-1:0] prod_d;
    logic [DATA_WIDTH-1:0]             sum_d;
    logic [DATA_WIDTH-1:0]             acc_next;

    logic                              s1_valid_q;
    logic [PARALLELISM*DATA_WIDTH-1:0] s1_prod_q;
    logic [ADDR_WIDTH-1:0]             s1_r_idx_q;
    logic                              s1_row_last_q;
    logic                              s1_mat_last_q;

    logic                              s2_valid_q;
    logic [DATA_WIDTH-1:0]             s2_sum_q;
    logic [ADDR_WIDTH-1:0]             s2_r_idx_q;
    logic                              s2_row_last_q;
    logic                              s2_mat_last_q;

    logic [DATA_WIDTH-1:0]             acc_q;
    logic [DATA_WIDTH-1:0]             out_data_q;
    logic [ADDR_WIDTH-1:0]             out_r_idx_q;
    logic                              out_last_q;
    logic                              out_valid_q;
    logic                              done_q;

    logic [ADDR_WIDTH-1:0]             prev_r_idx_q;
    logic                              prev_row_last_q;
    logic                              prev_seen_q;
    logic                              protocol_err_q;

    // Whole pipeline stalls together only when a result is held downstream.
    assign adv          = !out_valid_q || out_ready;
    assign in_ready     = adv && !rst;
    assign row_last_eff = in_row_last || in_mat_last;

    always_comb begin
        logic signed [2*DATA_WIDTH-1:0] full;
        full   = '0;
        prod_d = '0;
        for (int i = 0; i < PARALLELISM; i++) begin
            full = $signed(in_val[i*DATA_WIDTH +: DATA_WIDTH])
                 * $signed(in_x[i*DATA_WIDTH +: DATA_WIDTH]);
            prod_d[i*DATA_WIDTH +: DATA_WIDTH] = in_mask[i] ? full[DATA_WIDTH-1:0] : '0;
        end
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < PARALLELISM; i++) begin
            sum_d = sum_d + s1_prod_q[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign acc_next = acc_q + s2_sum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_prod_q     <= '0;
            s1_r_idx_q    <= '0;
            s1_row_last_q <= 1'b0;
            s1_mat_last_q <= 1'b0;
            s2_valid_q    <= 1'b0;
            s2_sum_q      <= '0;
            s2_r_idx_q    <= '0;
            s2_row_last_q <= 1'b0;
            s2_mat_last_q <= 1'b0;
        end else if (adv) begin
            s1_valid_q    <= in_valid;
            s1_prod_q     <= prod_d;
            s1_r_idx_q    <= in_r_idx;
            s1_row_last_q <= row_last_eff;
            s1_mat_last_q <= in_mat_last;
            s2_valid_q    <= s1_valid_q;
            s2_sum_q      <= sum_d;
            s2_r_idx_q    <= s1_r_idx_q;
            s2_row_last_q <= s1_row_last_q;
            s2_mat_last_q <= s1_mat_last_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            out_data_q  <= '0;
            out_r_idx_q <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (adv) begin
            if (s2_valid_q && s2_row_last_q) begin
                out_data_q  <= acc_next;
                out_r_idx_q <= s2_r_idx_q;
                out_last_q  <= s2_mat_last_q;
                out_valid_q <= 1'b1;
                acc_q       <= '0;
            end else begin
                if (s2_valid_q) begin
                    acc_q <= acc_next;
                end
                out_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= out_valid_q && out_ready && out_last_q;
        end
    end

    // Row changes are only legal right after a beat that closed its row.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_r_idx_q    <= '0;
            prev_row_last_q <= 1'b0;
            prev_seen_q     <= 1'b0;
            protocol_err_q  <= 1'b0;
        end else if (in_valid && in_ready) begin
            prev_r_idx_q    <= in_r_idx;
            prev_row_last_q <= row_last_eff;
            prev_seen_q     <= 1'b1;
            if (prev_seen_q && !prev_row_last_q && (in_r_idx != prev_r_idx_q)) begin
                protocol_err_q <= 1'b1;
            end
        end
    end

    assign out_data     = out_data_q;
    assign out_r_idx    = out_r_idx_q;
    assign out_last     = out_last_q;
    assign out_valid    = out_valid_q;
    assign done         = done_q;
    assign protocol_err = protocol_err_q;

endmodule
